switch_conditioner: RTL

Input-conditioning stage placed directly upstream of the digital lock controller. It synchronises and debounces the eight raw lock switches, then presents a stable switch bus together with one-cycle change pulses. The lock datapath consumes these outputs: the code multiplexer and all-switch AND use the clean bus, and the edge logic can use the pulses. This stage keeps bounce and metastability out of the lock FSM.

---
 rtl/switch_conditioner.sv | 68 ++++++
 1 files changed

// File: rtl/switch_conditioner.sv
// Synchronises and debounces raw lock switches into a stable bus plus one-cycle change pulses.
// Optional two-flop input synchroniser enabled by defining SWCOND_SYNC_EN.
module switch_conditioner #(
  parameter int              WIDTH           = 8,
  parameter int              DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE    = {WIDTH{1'b1}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_change,
  output logic             any_change,
  output logic             all_high
);

  localparam logic [7:0] TERMINAL = 8'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s;

`ifdef SWCOND_SYNC_EN
  logic [WIDTH-1:0] sync_a;
  logic [WIDTH-1:0] sync_b;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= RESET_VALUE;
      sync_b <= RESET_VALUE;
    end else begin
      sync_a <= sw_raw;
      sync_b <= sync_a;
    end
  end

  assign s = sync_b;
`else
  assign s = sw_raw;
`endif

  logic [7:0] cnt [WIDTH];

  // Any agreement between input and committed value restarts the full count.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_clean  <= RESET_VALUE;
      sw_change <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == sw_clean[i]) begin
          cnt[i]       <= '0;
          sw_change[i] <= 1'b0;
        end else if (cnt[i] == TERMINAL) begin
          sw_clean[i]  <= s[i];
          cnt[i]       <= '0;
          sw_change[i] <= 1'b1;
        end else begin
          cnt[i]       <= cnt[i] + 8'd1;
          sw_change[i] <= 1'b0;
        end
      end
    end
  end

  assign any_change = |sw_change;
  assign all_high   = &sw_clean;

endmodule
